mpmc11_wdf_sequencer: RTL and testbench

Sequences single-port write and read traffic onto the DDR memory-interface application bus for one mpmc11 channel. Accepts one command descriptor per transfer (address, direction, beat count), issues `app_en`/`app_cmd`/`app_addr` once per beat, and moves write data beats into the write-data FIFO with `app_wdf_wren`/`app_wdf_end`. Sits between the mpmc11 channel arbiter (upstream) and the memory-interface IP (downstream).

---
 rtl/mpmc11_pkg.sv | 15 +
 rtl/mpmc11_wdf_sequencer.sv | 120 ++++++++++++
 tb/tb_mpmc11_wdf_sequencer.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mpmc11_pkg.sv
// Shared types and command codes for the mpmc11 memory controller channel logic.
package mpmc11_pkg;

  typedef enum logic [2:0] {
    WSEQ_IDLE  = 3'd0,
    WSEQ_WDATA = 3'd1,
    WSEQ_WCMD  = 3'd2,
    WSEQ_RCMD  = 3'd3,
    WSEQ_DONE  = 3'd4
  } mpmc11_wseq_state_t;

  localparam logic [2:0] MPMC11_CMD_WRITE = 3'b000;
  localparam logic [2:0] MPMC11_CMD_READ  = 3'b001;

endpackage

// File: rtl/mpmc11_wdf_sequencer.sv
// Turns one command descriptor into per-beat app_en commands and, for writes,
// pushes each data beat into the write-data FIFO just ahead of its command.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high (req_valid/req_ready, wdat_valid/wdat_ready, app_en/app_rdy,
// app_wdf_wren/app_wdf_rdy); the offering side holds its payload until then.
module mpmc11_wdf_sequencer
  import mpmc11_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 29,
  parameter int ADDR_STEP  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [5:0]              req_len,
  input  logic                    wdat_valid,
  output logic                    wdat_ready,
  input  logic [DATA_WIDTH-1:0]   wdat,
  input  logic [DATA_WIDTH/8-1:0] wmask,
  output logic                    app_en,
  output logic [2:0]              app_cmd,
  output logic [ADDR_WIDTH-1:0]   app_addr,
  input  logic                    app_rdy,
  output logic                    app_wdf_wren,
  output logic                    app_wdf_end,
  output logic [DATA_WIDTH-1:0]   app_wdf_data,
  output logic [DATA_WIDTH/8-1:0] app_wdf_mask,
  input  logic                    app_wdf_rdy,
  output logic                    busy,
  output logic                    done,
  output mpmc11_wseq_state_t      dbg_state
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_INC = ADDR_WIDTH'(ADDR_STEP);

  mpmc11_wseq_state_t    state, state_nx;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [5:0]            beat_cnt;
  logic [5:0]            len_r;
  logic                  cmd_phase;
  logic                  last_beat;

  assign cmd_phase = (state == WSEQ_WCMD) || (state == WSEQ_RCMD);
  // Compared before the increment, so len_r = 63 completes without beat_cnt overflowing.
  assign last_beat = (beat_cnt == len_r);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WSEQ_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r   <= '0;
      beat_cnt <= '0;
      len_r    <= '0;
    end else if (state == WSEQ_IDLE && req_valid) begin
      addr_r   <= req_addr;
      len_r    <= req_len;
      beat_cnt <= '0;
    end else if (cmd_phase && app_rdy) begin
      addr_r   <= addr_r + ADDR_INC;
      beat_cnt <= beat_cnt + 6'd1;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      WSEQ_IDLE:  if (req_valid) state_nx = req_we ? WSEQ_WDATA : WSEQ_RCMD;
      WSEQ_WDATA: if (wdat_valid && app_wdf_rdy) state_nx = WSEQ_WCMD;
      WSEQ_WCMD:  if (app_rdy) state_nx = last_beat ? WSEQ_DONE : WSEQ_WDATA;
      WSEQ_RCMD:  if (app_rdy && last_beat) state_nx = WSEQ_DONE;
      WSEQ_DONE:  state_nx = WSEQ_IDLE;
      default:    state_nx = WSEQ_IDLE;
    endcase
  end

  always_comb begin
    req_ready    = 1'b0;
    wdat_ready   = 1'b0;
    app_en       = 1'b0;
    app_cmd      = 3'b000;
    app_addr     = '0;
    app_wdf_wren = 1'b0;
    done         = 1'b0;
    unique case (state)
      WSEQ_IDLE:  req_ready = 1'b1;
      WSEQ_WDATA: begin
        wdat_ready   = app_wdf_rdy;
        app_wdf_wren = wdat_valid;
      end
      WSEQ_WCMD: begin
        app_en   = 1'b1;
        app_cmd  = MPMC11_CMD_WRITE;
        app_addr = addr_r;
      end
      WSEQ_RCMD: begin
        app_en   = 1'b1;
        app_cmd  = MPMC11_CMD_READ;
        app_addr = addr_r;
      end
      WSEQ_DONE:  done = 1'b1;
      default:    ;
    endcase
  end

  // Each beat is its own BL8 burst, so every strobed beat also ends its burst.
  assign app_wdf_end  = app_wdf_wren;
  assign app_wdf_data = wdat;
  assign app_wdf_mask = wmask;
  assign busy         = (state != WSEQ_IDLE);
  assign dbg_state    = state;

endmodule

// File: tb/tb_mpmc11_wdf_sequencer.sv
// Randomised and directed bench for mpmc11_wdf_sequencer; expected command and
// write-data streams come from descriptor arithmetic, checked by a negedge monitor.
module tb_mpmc11_wdf_sequencer;
  import mpmc11_pkg::*;

  localparam int DW = 128;
  localparam int AW = 29;
  localparam int MW = DW / 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic           req_we = 1'b0;
  logic [AW-1:0]  req_addr = '0;
  logic [5:0]     req_len = '0;
  logic           wdat_valid = 1'b0;
  logic           wdat_ready;
  logic [DW-1:0]  wdat = '0;
  logic [MW-1:0]  wmask = '0;
  logic           app_en;
  logic [2:0]     app_cmd;
  logic [AW-1:0]  app_addr;
  logic           app_rdy = 1'b1;
  logic           app_wdf_wren;
  logic           app_wdf_end;
  logic [DW-1:0]  app_wdf_data;
  logic [MW-1:0]  app_wdf_mask;
  logic           app_wdf_rdy = 1'b1;
  logic           busy;
  logic           done;
  mpmc11_wseq_state_t dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: driven by a test
  bit mon_en = 1'b0;

  logic [AW+2:0]    exp_cmd_q[$];
  logic [MW+DW-1:0] exp_wdf_q[$];
  int               en_cyc_q[$];
  int exp_done = 0;
  int done_seen = 0;
  int last_acc_cyc = 0;
  int n_cmd_acc = 0;
  int n_wdf_acc = 0;

  mpmc11_wdf_sequencer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len),
    .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat(wdat), .wmask(wmask),
    .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) begin
      app_rdy = 1'b1;
      app_wdf_rdy = 1'b1;
    end else if (rdy_mode == 1) begin
      app_rdy = ($urandom_range(0, 3) != 0);
      app_wdf_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic           prev_cmd_hold = 1'b0;
  logic [2:0]     prev_cmd;
  logic [AW-1:0]  prev_addr;
  logic           prev_wdf_hold = 1'b0;
  logic [DW-1:0]  prev_data;
  logic [MW-1:0]  prev_mask;

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (app_en || app_wdf_wren) chk("en_wren_exclusive", 160'(app_en & app_wdf_wren), 160'd0);
      if (prev_cmd_hold) chk("cmd_hold", {app_en, app_cmd, app_addr}, {1'b1, prev_cmd, prev_addr});
      if (prev_wdf_hold)
        chk("wdf_hold", {app_wdf_wren, app_wdf_mask, app_wdf_data}, {1'b1, prev_mask, prev_data});
      if (app_en && app_rdy) begin
        if (exp_cmd_q.size() == 0) chk("cmd_unexpected", {app_cmd, app_addr}, 160'd0 - 160'd1);
        else chk("cmd", {app_cmd, app_addr}, exp_cmd_q.pop_front());
        en_cyc_q.push_back(cyc);
        last_acc_cyc = cyc;
        n_cmd_acc++;
      end
      if (app_wdf_wren && app_wdf_rdy) begin
        if (exp_wdf_q.size() == 0) chk("wdf_unexpected", {app_wdf_mask, app_wdf_data}, 160'd0 - 160'd1);
        else chk("wdf_beat", {app_wdf_mask, app_wdf_data}, exp_wdf_q.pop_front());
        chk("wdf_end", 160'(app_wdf_end), 160'd1);
        n_wdf_acc++;
      end
      if (done) begin
        chk("done_after_last_cmd", 160'(cyc - last_acc_cyc), 160'd1);
        done_seen++;
      end
      prev_cmd_hold = app_en && !app_rdy;
      prev_cmd      = app_cmd;
      prev_addr     = app_addr;
      prev_wdf_hold = app_wdf_wren && !app_wdf_rdy;
      prev_data     = app_wdf_data;
      prev_mask     = app_wdf_mask;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic present_beat(input bit use_a5);
    logic [DW-1:0] a5;
    a5 = {MW{8'hA5}};
    wdat  = use_a5 ? a5 : {$urandom(), $urandom(), $urandom(), $urandom()};
    wmask = use_a5 ? '0 : MW'($urandom());
    wdat_valid = 1'b1;
    exp_wdf_q.push_back({wmask, wdat});
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (!busy && exp_cmd_q.size() == 0 && exp_wdf_q.size() == 0) return;
    end
    chk("idle_timeout", 160'(busy), 160'd0);
  endtask

  task automatic run_desc(input logic we, input logic [AW-1:0] addr, input logic [5:0] len,
                          input bit chk_lat, input bit use_a5);
    int acc_cyc;
    int idx;
    bit ok;
    logic [AW-1:0] a;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_len = len;
    for (int i = 0; i <= int'(len); i++) begin
      a = addr + AW'(i * 8);
      exp_cmd_q.push_back({we ? MPMC11_CMD_WRITE : MPMC11_CMD_READ, a});
    end
    exp_done++;
    if (we) present_beat(use_a5);
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin chk("accept_timeout", 160'(req_ready), 160'd1); req_valid = 1'b0; return; end
    acc_cyc = cyc;
    idx = en_cyc_q.size();
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (we) begin
      for (int b = 0; b <= int'(len); b++) begin
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
          @(negedge clk);
          if (wdat_valid && wdat_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin chk("beat_timeout", 160'(wdat_ready), 160'd1); wdat_valid = 1'b0; return; end
        @(posedge clk); #1;
        wdat_valid = 1'b0;
        if (b < int'(len)) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          present_beat(use_a5);
        end
      end
    end
    wait_idle();
    if (chk_lat) begin
      if (en_cyc_q.size() > idx) chk("first_cmd_latency", 160'(en_cyc_q[idx] - acc_cyc), we ? 160'd2 : 160'd1);
      else chk("first_cmd_missing", 160'(en_cyc_q.size()), 160'(idx + 1));
    end
  endtask

  // ---------------- stimulus ----------------
  int n_acc;
  bit found;
  int acc_q[$];
  int w0, c0;

  initial begin
    #3;
    chk("rst_outputs", {req_ready, app_en, app_wdf_wren, app_wdf_end, wdat_ready, busy, done, app_cmd, app_addr},
        {1'b1, 6'b0, 3'b0, 29'b0});
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset in the middle of a write, parked in WCMD on beat 3
    rdy_mode = 2;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 29'h200; req_len = 6'd5;
    wdat_valid = 1'b1; wdat = '0; wmask = '0; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_acc = 0; found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dbg_state == WSEQ_WCMD && n_acc == 3) begin found = 1'b1; break; end
      if (app_en && app_rdy) n_acc++;
    end
    chk("rst_reach_beat3", 160'(found), 160'd1);
    chk("rst_pre_addr", 160'(app_addr), 160'h218);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_outputs",
        {req_ready, app_en, app_wdf_wren, app_wdf_end, wdat_ready, busy, done, app_cmd, app_addr},
        {1'b1, 6'b0, 3'b0, 29'b0});
    chk("rst_async_state", 160'(dbg_state), 160'(WSEQ_IDLE));
    @(posedge clk); #1;
    rst = 1'b0; wdat_valid = 1'b0; rdy_mode = 0;
    @(negedge clk);
    chk("post_rst_ready", {req_ready, busy, done}, 160'b100);
    mon_en = 1'b1;
    run_desc(1'b0, 29'h100, 6'd0, 1'b1, 1'b0);

    // Read burst of 4 with app_rdy always high
    run_desc(1'b0, 29'h1000, 6'd3, 1'b1, 1'b0);

    // Single write beat of 0xA5
    run_desc(1'b1, 29'h2000, 6'd0, 1'b1, 1'b1);

    // Two-beat write with FIFO and command backpressure
    rdy_mode = 2; app_wdf_rdy = 1'b0; app_rdy = 1'b1;
    w0 = n_wdf_acc; c0 = n_cmd_acc;
    fork
      run_desc(1'b1, 29'h3000, 6'd1, 1'b0, 1'b0);
      begin
        for (int t = 0; t < 50; t++) begin @(negedge clk); if (app_wdf_wren) break; end
        repeat (3) @(posedge clk);
        #1 app_wdf_rdy = 1'b1;
        for (int t = 0; t < 50; t++) begin @(negedge clk); if (app_en && app_rdy) break; end
        @(posedge clk); #1 app_rdy = 1'b0;
        for (int t = 0; t < 50; t++) begin @(negedge clk); if (app_en) break; end
        repeat (2) @(posedge clk);
        #1 app_rdy = 1'b1;
      end
    join
    chk("bp_wren_count", 160'(n_wdf_acc - w0), 160'd2);
    chk("bp_cmd_count", 160'(n_cmd_acc - c0), 160'd2);

    // 64-beat write across the top of the address space, random backpressure
    rdy_mode = 1;
    run_desc(1'b1, 29'h1FFF_FFF0, 6'd63, 1'b0, 1'b0);

    // req_valid held high: the next accept lands the cycle after DONE
    rdy_mode = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 29'h40; req_len = 6'd1;
    for (int d = 0; d < 2; d++) begin
      exp_cmd_q.push_back({MPMC11_CMD_READ, 29'h40});
      exp_cmd_q.push_back({MPMC11_CMD_READ, 29'h48});
      exp_done++;
    end
    acc_q.delete();
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (req_valid && req_ready) acc_q.push_back(cyc);
      else if (acc_q.size() == 1) chk("ready_low_while_busy", 160'(req_ready), 160'd0);
      if (acc_q.size() == 2) break;
    end
    @(posedge clk); #1 req_valid = 1'b0;
    if (acc_q.size() == 2) chk("held_req_gap", 160'(acc_q[1] - acc_q[0]), 160'd4);
    else chk("held_req_accepts", 160'(acc_q.size()), 160'd2);
    wait_idle();

    // Random traffic
    rdy_mode = 1;
    for (int n = 0; n < 24; n++)
      run_desc(1'($urandom_range(0, 1)), AW'($urandom()), 6'($urandom_range(0, 12)), 1'b0, 1'b0);
    rdy_mode = 0;
    repeat (3) @(negedge clk);

    chk("done_count", 160'(done_seen), 160'(exp_done));
    chk("cmd_queue_empty", 160'(exp_cmd_q.size()), 160'd0);
    chk("wdf_queue_empty", 160'(exp_wdf_q.size()), 160'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
